// File: rtl/gcn_mem_fetch.sv
// Fetch engine for one GCN layer: buffers WEIGHT_COLS weight columns, then
// streams FEATURE_ROWS feature rows to a downstream consumer with valid/ready.
module gcn_mem_fetch #(
  parameter int FEATURE_ROWS  = 6,
  parameter int FEATURE_COLS  = 96,
  parameter int WEIGHT_ROWS   = 96,
  parameter int WEIGHT_COLS   = 3,
  parameter int DATA_WIDTH    = 5,
  parameter int ADDRESS_WIDTH = 13,
  parameter int FEATURE_BASE  = 512
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [WEIGHT_ROWS*DATA_WIDTH-1:0]     data_in,
  output logic [ADDRESS_WIDTH-1:0]              read_address,
  output logic                                  enable_read,
  input  logic [$clog2(WEIGHT_COLS)-1:0]        weight_sel,
  output logic [WEIGHT_ROWS*DATA_WIDTH-1:0]     weight_col_out,
  output logic [FEATURE_COLS*DATA_WIDTH-1:0]    feature_row_out,
  output logic [$clog2(FEATURE_ROWS)-1:0]       row_index,
  output logic                                  row_valid,
  input  logic                                  row_ready,
  output logic                                  busy,
  output logic                                  done
);

  localparam int WCNT_W = $clog2(WEIGHT_COLS + 1);
  localparam int ROW_W  = $clog2(FEATURE_ROWS);
  localparam int WCOL_W = WEIGHT_ROWS * DATA_WIDTH;
  localparam int FEAT_W = FEATURE_COLS * DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_W,
    S_FETCH_F,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t                   r_state;
  logic [WCNT_W-1:0]        r_w_cnt;
  logic [ROW_W-1:0]         r_f_cnt;
  logic [ADDRESS_WIDTH-1:0] r_read_address;
  logic                     r_enable_read;
  logic                     r_row_valid;
  logic                     r_busy;
  logic                     r_done;
  logic [FEAT_W-1:0]        r_feat;
  logic [WCOL_W-1:0]        r_wbuf [WEIGHT_COLS];
  logic [FEAT_W-1:0]        w_feat_in;

  // A memory row may be narrower or wider than a feature row; extra
  // feature elements read as zero and extra memory elements are dropped.
  // NOTE: always_comb assigns every output a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_feat_in = '0;
    for (int i = 0; i < FEATURE_COLS; i++) begin
      if (i < WEIGHT_ROWS) w_feat_in[i*DATA_WIDTH +: DATA_WIDTH] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Outputs are registered alongside the state: each transition loads the
  // values the destination state must present, so the memory sees the
  // address in the same cycle the capture edge closes it.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_w_cnt        <= '0;
      r_f_cnt        <= '0;
      r_read_address <= '0;
      r_enable_read  <= 1'b0;
      r_row_valid    <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_feat         <= '0;
      // NOTE: the weight buffer is a small flop array, not a RAM macro, so
      // it is cleared on reset; a true RAM would be left unreset.
      for (int c = 0; c < WEIGHT_COLS; c++) r_wbuf[c] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state        <= S_FETCH_W;
            r_w_cnt        <= '0;
            r_f_cnt        <= '0;
            r_read_address <= '0;
            r_enable_read  <= 1'b1;
            r_busy         <= 1'b1;
          end
        end
        S_FETCH_W: begin
          r_wbuf[r_w_cnt] <= data_in;
          r_w_cnt         <= r_w_cnt + WCNT_W'(1);
          if (r_w_cnt == WCNT_W'(WEIGHT_COLS - 1)) begin
            r_state        <= S_FETCH_F;
            r_read_address <= ADDRESS_WIDTH'(FEATURE_BASE + int'(r_f_cnt));
          end else begin
            r_read_address <= ADDRESS_WIDTH'(int'(r_w_cnt) + 1);
          end
        end
        S_FETCH_F: begin
          r_feat        <= w_feat_in;
          r_state       <= S_PRESENT;
          r_enable_read <= 1'b0;
          r_row_valid   <= 1'b1;
        end
        S_PRESENT: begin
          if (row_ready) begin
            r_row_valid <= 1'b0;
            if (r_f_cnt == ROW_W'(FEATURE_ROWS - 1)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_f_cnt        <= r_f_cnt + ROW_W'(1);
              r_state        <= S_FETCH_F;
              r_enable_read  <= 1'b1;
              r_read_address <= ADDRESS_WIDTH'(FEATURE_BASE + int'(r_f_cnt) + 1);
            end
          end
        end
        S_DONE: begin
          if (!start) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign read_address    = r_read_address;
  assign enable_read     = r_enable_read;
  assign row_valid       = r_row_valid;
  assign busy            = r_busy;
  assign done            = r_done;
  assign row_index       = r_f_cnt;
  assign feature_row_out = r_feat;
  assign weight_col_out  = (int'(weight_sel) < WEIGHT_COLS) ? r_wbuf[weight_sel] : '0;

endmodule
